// File: rtl/fa_ha.sv
// -----------------------------------------------------------------------------
// fa_ha -- single-bit full adder built from two cascaded half adders.
//
// Computes {carry, sum} = a + b + c. The combinational result is presented
// directly on sum/carry, and a registered copy is presented on sum_q/carry_q
// for use inside clocked datapaths or ripple chains built by the parent.
//
// Ports:
//   clk      in   1  system clock, rising-edge active; clocks only sum_q/carry_q
//   rst      in   1  asynchronous, active-high reset; clears sum_q/carry_q
//   a        in   1  addend bit
//   b        in   1  addend bit
//   c        in   1  carry-in bit
//   sum      out  1  combinational sum, a ^ b ^ c
//   carry    out  1  combinational carry-out, majority(a, b, c)
//   sum_q    out  1  sum registered on the rising edge of clk
//   carry_q  out  1  carry registered on the rising edge of clk
// -----------------------------------------------------------------------------
module fa_ha (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry,
    output logic sum_q,
    output logic carry_q
);

    // Half adder as a pure function: returns {carry, sum} of two bits.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [1:0] ha1_p0;   // {c1, s1} = a + b
    logic [1:0] ha2_p0;   // {c2, sum} = s1 + c

    always_comb begin
        ha1_p0 = half_add(a, b);
        ha2_p0 = half_add(ha1_p0[0], c);
    end

    // c1 and c2 can never both be 1 (c1 implies s1 = 0, which forces c2 = 0),
    // so the OR is really a merge of two mutually exclusive carry sources.
    assign sum   = ha2_p0[0];
    assign carry = ha1_p0[1] | ha2_p0[1];

    // ---- stage p0 -> registered outputs --------------------------------------
    // Loads every cycle; reset clears the pair immediately, without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum;
            carry_q <= carry;
        end
    end

endmodule

// File: tb/tb_fa_ha.sv
// -----------------------------------------------------------------------------
// tb_fa_ha -- self-checking bench for fa_ha.
//
// Reference: {carry, sum} is the integer a + b + c; {carry_q, sum_q} is that
// integer as sampled at the last rising clk edge, or 0 while rst is high.
// -----------------------------------------------------------------------------
module tb_fa_ha;

    logic clk = 1'b0;
    logic rst;
    logic a, b, c;
    logic sum, carry, sum_q, carry_q;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    fa_ha dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .sum     (sum),
        .carry   (carry),
        .sum_q   (sum_q),
        .carry_q (carry_q)
    );

    always #5 clk = ~clk;

    // Behavioural reference: plain integer addition of the three bits.
    function automatic logic [1:0] ref_add(input logic x, input logic y, input logic z);
        int s;
        s = int'(x) + int'(y) + int'(z);
        return 2'(s);
    endfunction

    // Registered reference: last sampled sum, cleared asynchronously by rst.
    logic [1:0] exp_q = 2'b00;
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= 2'b00;
        else     exp_q <= ref_add(a, b, c);
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Continuous compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("comb_model", {carry, sum}, ref_add(a, b, c));
            chk("reg_model", {carry_q, sum_q}, exp_q);
        end
    end

    // Apply new inputs just after a rising edge so they are stable before the next.
    task automatic apply(input logic [2:0] v);
        @(posedge clk);
        #2;
        {a, b, c} = v;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [1:0] sweep_exp [9];
    logic [2:0] sweep_in  [9];
    logic [2:0] carry_in  [3];

    initial begin : main
        logic [1:0] prev;
        sweep_in  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
        sweep_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        carry_in  = '{3'b110, 3'b101, 3'b011};

        rst = 1'b1;
        {a, b, c} = 3'b111;
        #1;
        chk("reset_state_q", {carry_q, sum_q}, 2'b00);
        chk("comb_in_reset", {carry, sum}, 2'b11);
        @(posedge clk);
        #1;
        chk("reset_held_q", {carry_q, sum_q}, 2'b00);
        #2;
        rst = 1'b0;
        checking = 1'b1;

        // Exhaustive sweep, each pattern held for 10 cycles.
        for (int i = 0; i < 9; i++) begin
            apply(sweep_in[i]);
            #1;
            chk($sformatf("sweep_comb_%0d", i), {carry, sum}, sweep_exp[i]);
            @(posedge clk);
            #1;
            chk($sformatf("sweep_reg_%0d", i), {carry_q, sum_q}, sweep_exp[i]);
            repeat (8) @(posedge clk);
        end

        // Asynchronous reset while outputs hold 11.
        apply(3'b111);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_q", {carry_q, sum_q}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_q", {carry_q, sum_q}, 2'b00);
        chk("async_reset_comb", {carry, sum}, 2'b11);
        @(posedge clk);
        #1;
        chk("reset_hold_q", {carry_q, sum_q}, 2'b00);
        chk("reset_hold_comb", {carry, sum}, 2'b11);

        // Release with 011: zero until the first edge, then 10.
        #1;
        {a, b, c} = 3'b011;
        #1;
        rst = 1'b0;
        #1;
        chk("release_before_edge", {carry_q, sum_q}, 2'b00);
        @(posedge clk);
        #1;
        chk("release_after_edge", {carry_q, sum_q}, 2'b10);

        // Carry through c1 (110) and through c2 (101, 011).
        for (int i = 0; i < 3; i++) begin
            apply(carry_in[i]);
            #1;
            chk($sformatf("carry_path_%0d", i), {carry, sum}, 2'b10);
        end

        // Randomized one-cycle latency run.
        prev = ref_add(a, b, c);
        for (int i = 0; i < 100; i++) begin
            apply(3'($urandom_range(0, 7)));
            // The edge just before this apply captured the previous inputs.
            chk("rand_latency", {carry_q, sum_q}, prev);
            prev = ref_add(a, b, c);
        end
        @(posedge clk);
        #1;
        chk("rand_final", {carry_q, sum_q}, prev);

        @(negedge clk);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
